eth_rx_frame_checker: RTL and testbench
=======================================

// Module: eth_rx_frame_checker
// PURPOSE
//  Receive-side companion to the top-level test-frame generator. Sits on the eth_mac RX AXI-Stream
//  output (clk_mac domain), checks every received frame against the fixed test pattern (broadcast
//  DA, EtherType ETHERTYPE, payload byte i = i[7:0]), classifies it good/bad/error, keeps saturating
//  counters and captures the first BUF_DEPTH bytes of the most recent frame for LED/debug readout.
// PARAMETERS
//  ETHERTYPE   16'hEBEB  expected bytes 12..13 (byte 12 = [15:8])
//  FRAME_LEN   64        exact expected frame length in bytes (FCS already stripped by MAC), 15..2047
//  CNT_W       16        width of each frame counter
//  BUF_DEPTH   64        capture buffer depth in bytes (power of 2)
// PORTS
//  clk_mac     in   1      MAC clock; all logic on rising edge
//  rst         in   1      asynchronous, active-high reset
//  rx_tdata    in   8      RX stream byte (from rx_axis_mac_tdata)
//  rx_tvalid   in   1      byte valid; no backpressure, every valid beat is consumed
//  rx_tlast    in   1      last byte of frame
//  rx_tuser    in   1      frame error flag, sampled only on the tlast beat
//  clr_cnt     in   1      synchronous clear of all three counters
//  good_cnt    out  CNT_W  frames matching pattern and length, tuser=0
//  bad_cnt     out  CNT_W  frames with tuser=0 failing pattern or length
//  err_cnt     out  CNT_W  frames ending with tuser=1
//  frame_done  out  1      one-cycle pulse, cycle after the tlast beat
//  frame_ok    out  1      classification of last frame (1 = good); updated with frame_done
//  last_len    out  11     byte count of last frame, saturating at 2047; updated with frame_done
//  rd_addr     in   log2(BUF_DEPTH)  capture buffer read address
//  rd_data     out  8      buffer byte at rd_addr, registered, 1-cycle read latency
// BEHAVIOUR
//  - Reset: all counters 0, frame_done 0, frame_ok 0, last_len 0, rd_data 0, state IDLE, idx 0.
//    Buffer contents undefined after reset. Reset mid-frame discards it; the next valid beat is
//    treated as byte 0 of a new frame.
//  - States: IDLE -> RECV on a valid beat without tlast; IDLE -> IDLE on a valid beat with tlast
//    (1-byte frame, classified immediately); RECV -> IDLE on a valid beat with tlast. Cycles with
//    rx_tvalid=0 hold all state (gaps within a frame allowed).
//  - idx (11 bits) = byte index of current beat; increments per valid beat, saturates at 2047,
//    returns to 0 after tlast.
//  - Match flag set at frame start, cleared on any mismatch: idx 0..5 must be 8'hFF; idx 6..11
//    ignored; idx 12/13 = ETHERTYPE[15:8]/[7:0]; idx 14..FRAME_LEN-1 must equal idx[7:0];
//    any beat with idx >= FRAME_LEN clears match (oversize). Length = idx+1 at tlast must equal
//    FRAME_LEN (undersize clears match).
//  - Classification on tlast beat, applied next cycle: tuser=1 -> err_cnt++ (frame_ok=0, regardless
//    of match); else match -> good_cnt++, frame_ok=1; else bad_cnt++, frame_ok=0.
//  - Counters saturate at all-ones. clr_cnt zeroes counters; if clr_cnt coincides with a
//    classification update, clear wins and that frame is not counted (frame_done/frame_ok/last_len
//    still update).
//  - Capture: beats with idx < BUF_DEPTH written to buffer[idx]; later bytes not written. Bytes from
//    the previous frame beyond the new frame's length remain. rd_data <= buffer[rd_addr] each cycle;
//    a write and read to the same address in the same cycle returns the old byte.
// TESTING
//  1. 64-byte frame FF x6, 00 x6, EB EB, 0E..3F, tuser=0 -> frame_done 1 cycle after tlast,
//     frame_ok=1, last_len=64, good_cnt=1, bad/err=0.
//  2. Same frame with byte 20 = 8'h00 -> bad_cnt=1, frame_ok=0; rd_addr=20 -> rd_data=8'h00 next cycle.
//  3. Correct frame with tuser=1 on tlast -> err_cnt=1, good_cnt unchanged; 63- and 65-byte
//     correct-prefix frames -> bad_cnt +2, last_len 63 then 65.
//  4. Correct frame with random tvalid gaps (≤5 idle cycles) -> good_cnt=1; single-beat frame
//     (tvalid&tlast) -> bad_cnt+1, last_len=1.
//  5. CNT_W=4: 17 good frames -> good_cnt=15 (saturated); clr_cnt asserted on frame_done cycle
//     -> all counters 0, frame_ok=1.
//  6. Assert rst after byte 30 of a frame, release, send correct frame -> good_cnt=1, no
//     frame_done for the aborted frame.

Source files
------------

// File: rtl/eth_rx_frame_checker.sv
// eth_rx_frame_checker: checks received test frames against the fixed pattern, counts and captures them
module eth_rx_frame_checker #(
    parameter logic [15:0] ETHERTYPE = 16'hEBEB,
    parameter int          FRAME_LEN = 64,
    parameter int          CNT_W     = 16,
    parameter int          BUF_DEPTH = 64,
    localparam int         AW        = $clog2(BUF_DEPTH)
) (
    input  logic             clk_mac,
    input  logic             rst,
    input  logic [7:0]       rx_tdata,
    input  logic             rx_tvalid,
    input  logic             rx_tlast,
    input  logic             rx_tuser,
    input  logic             clr_cnt,
    output logic [CNT_W-1:0] good_cnt,
    output logic [CNT_W-1:0] bad_cnt,
    output logic [CNT_W-1:0] err_cnt,
    output logic             frame_done,
    output logic             frame_ok,
    output logic [10:0]      last_len,
    input  logic [AW-1:0]    rd_addr,
    output logic [7:0]       rd_data
);
    localparam logic       IDLE = 1'b0;
    localparam logic       RECV = 1'b1;
    localparam logic [10:0] FL  = 11'(FRAME_LEN);
    localparam logic [11:0] BD  = 12'(BUF_DEPTH);

    logic             state_q, state_d;
    logic [10:0]      idx_q, idx_d, len;
    logic             match_q, match_d, match_cur, byte_ok, beat_last, is_good;
    logic [CNT_W-1:0] good_q, good_d, bad_q, bad_d, err_q, err_d;
    logic             done_q, ok_q, ok_d;
    logic [10:0]      len_q, len_d;
    logic [7:0]       rd_q;
    logic [7:0]       mem [BUF_DEPTH];

    function automatic logic [CNT_W-1:0] sat_inc(input logic [CNT_W-1:0] c);
        return &c ? c : c + 1'b1;
    endfunction

    always_comb begin
        byte_ok = 1'b1;
        if (idx_q >= FL)
            byte_ok = 1'b0;
        else if (idx_q < 11'd6)
            byte_ok = rx_tdata == 8'hFF;
        else if (idx_q == 11'd12)
            byte_ok = rx_tdata == ETHERTYPE[15:8];
        else if (idx_q == 11'd13)
            byte_ok = rx_tdata == ETHERTYPE[7:0];
        else if (idx_q >= 11'd14)
            byte_ok = rx_tdata == idx_q[7:0];
    end

    // a new frame starts with match assumed true; len doubles as the saturating idx increment
    assign match_cur = (state_q == IDLE || match_q) && byte_ok;
    assign len       = &idx_q ? idx_q : idx_q + 11'd1;
    assign beat_last = rx_tvalid && rx_tlast;
    assign is_good   = match_cur && len == FL;

    always_comb begin
        state_d = rx_tvalid ? (rx_tlast ? IDLE : RECV) : state_q;
        idx_d   = rx_tvalid ? (rx_tlast ? 11'd0 : len) : idx_q;
        match_d = rx_tvalid ? match_cur : match_q;
        ok_d    = beat_last ? !rx_tuser && is_good : ok_q;
        len_d   = beat_last ? len : len_q;
        good_d  = clr_cnt ? '0 : (beat_last && !rx_tuser && is_good) ? sat_inc(good_q) : good_q;
        bad_d   = clr_cnt ? '0 : (beat_last && !rx_tuser && !is_good) ? sat_inc(bad_q) : bad_q;
        err_d   = clr_cnt ? '0 : (beat_last && rx_tuser) ? sat_inc(err_q) : err_q;
    end

    always_ff @(posedge clk_mac or posedge rst) begin
        if (rst) begin
            state_q <= IDLE;
            idx_q   <= '0;
            match_q <= 1'b0;
            good_q  <= '0;
            bad_q   <= '0;
            err_q   <= '0;
            done_q  <= 1'b0;
            ok_q    <= 1'b0;
            len_q   <= '0;
            rd_q    <= '0;
        end else begin
            state_q <= state_d;
            idx_q   <= idx_d;
            match_q <= match_d;
            good_q  <= good_d;
            bad_q   <= bad_d;
            err_q   <= err_d;
            done_q  <= beat_last;
            ok_q    <= ok_d;
            len_q   <= len_d;
            rd_q    <= mem[rd_addr];
        end
    end

    always_ff @(posedge clk_mac) begin
        if (rx_tvalid && {1'b0, idx_q} < BD)
            mem[idx_q[AW-1:0]] <= rx_tdata;
    end

    assign good_cnt   = good_q;
    assign bad_cnt    = bad_q;
    assign err_cnt    = err_q;
    assign frame_done = done_q;
    assign frame_ok   = ok_q;
    assign last_len   = len_q;
    assign rd_data    = rd_q;
endmodule

// File: tb/tb_eth_rx_frame_checker.sv
// tb_eth_rx_frame_checker: randomized frames checked every cycle against a frame-level reference model
module tb_eth_rx_frame_checker;
    localparam int          FLEN = 64;
    localparam int          BDEP = 64;
    localparam logic [15:0] ETH  = 16'hEBEB;

    logic        clk_mac = 1'b0;
    logic        rst = 1'b1;
    logic [7:0]  rx_tdata = '0;
    logic        rx_tvalid = 1'b0, rx_tlast = 1'b0, rx_tuser = 1'b0, clr_cnt = 1'b0;
    logic [5:0]  rd_addr = '0;
    logic [15:0] good_cnt, bad_cnt, err_cnt;
    logic [3:0]  good4, bad4, err4;
    logic        frame_done, frame_ok, done4, ok4;
    logic [10:0] last_len, len4;
    logic [7:0]  rd_data, rd4;

    int tests = 0, fails = 0;
    bit started = 0, rand_rd = 1;

    eth_rx_frame_checker dut (
        .clk_mac(clk_mac), .rst(rst), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .rx_tuser(rx_tuser), .clr_cnt(clr_cnt), .good_cnt(good_cnt), .bad_cnt(bad_cnt), .err_cnt(err_cnt),
        .frame_done(frame_done), .frame_ok(frame_ok), .last_len(last_len), .rd_addr(rd_addr), .rd_data(rd_data)
    );

    eth_rx_frame_checker #(.CNT_W(4)) dut4 (
        .clk_mac(clk_mac), .rst(rst), .rx_tdata(rx_tdata), .rx_tvalid(rx_tvalid), .rx_tlast(rx_tlast),
        .rx_tuser(rx_tuser), .clr_cnt(clr_cnt), .good_cnt(good4), .bad_cnt(bad4), .err_cnt(err4),
        .frame_done(done4), .frame_ok(ok4), .last_len(len4), .rd_addr(rd_addr), .rd_data(rd4)
    );

    always #5 clk_mac = ~clk_mac;

    task automatic chk(input string name, input int act, input int exp);
        tests++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // reference model: whole frames are collected and judged against the pattern rules at tlast
    logic [7:0] fq[$];
    logic [7:0] mbuf [BDEP];
    bit         known [BDEP];
    int         n_good = 0, n_bad = 0, n_err = 0;
    logic       e_done = 0, e_ok = 0, e_rd_known = 1;
    int         e_len = 0;
    logic [7:0] e_rd = 0;

    function automatic logic frame_good(input logic [7:0] f[$]);
        if (f.size() != FLEN) return 1'b0;
        for (int i = 0; i < FLEN; i++) begin
            if (i < 6 && f[i] != 8'hFF) return 1'b0;
            if (i == 12 && f[i] != ETH[15:8]) return 1'b0;
            if (i == 13 && f[i] != ETH[7:0]) return 1'b0;
            if (i >= 14 && f[i] != 8'(i)) return 1'b0;
        end
        return 1'b1;
    endfunction

    function automatic int sat(input int n, input int mx);
        return n > mx ? mx : n;
    endfunction

    initial forever begin
        @(posedge clk_mac);
        if (rst) begin
            e_done = 0; e_ok = 0; e_len = 0; e_rd = 0; e_rd_known = 1;
            n_good = 0; n_bad = 0; n_err = 0;
            fq.delete();
            for (int i = 0; i < BDEP; i++) known[i] = 0;
        end else begin
            e_rd_known = known[rd_addr];
            e_rd = mbuf[rd_addr];
            e_done = 0;
            if (rx_tvalid) begin
                if (fq.size() < BDEP) begin
                    mbuf[fq.size()] = rx_tdata;
                    known[fq.size()] = 1;
                end
                fq.push_back(rx_tdata);
                if (rx_tlast) begin
                    e_done = 1;
                    e_len = sat(fq.size(), 2047);
                    e_ok = !rx_tuser && frame_good(fq);
                    if (rx_tuser) n_err++;
                    else if (e_ok) n_good++;
                    else n_bad++;
                    fq.delete();
                end
            end
            if (clr_cnt) begin
                n_good = 0; n_bad = 0; n_err = 0;
            end
        end
    end

    initial forever begin
        @(negedge clk_mac);
        if (started && !rst) begin
            chk("frame_done", frame_done, e_done);
            chk("frame_ok", frame_ok, e_ok);
            chk("last_len", last_len, e_len);
            chk("good_cnt", good_cnt, sat(n_good, 65535));
            chk("bad_cnt", bad_cnt, sat(n_bad, 65535));
            chk("err_cnt", err_cnt, sat(n_err, 65535));
            chk("good4", good4, sat(n_good, 15));
            chk("bad4", bad4, sat(n_bad, 15));
            chk("err4", err4, sat(n_err, 15));
            chk("done4", done4, e_done);
            if (e_rd_known) chk("rd_data", rd_data, e_rd);
        end
    end

    task automatic drive(input logic v, input logic [7:0] d, input logic l, input logic u, input logic c);
        @(posedge clk_mac);
        #1;
        rx_tvalid = v; rx_tdata = d; rx_tlast = l; rx_tuser = u; clr_cnt = c;
        if (rand_rd) rd_addr = 6'($urandom);
    endtask

    function automatic logic [7:0] pat(input int i);
        if (i < 6) return 8'hFF;
        if (i < 12) return 8'($urandom);
        if (i == 12) return ETH[15:8];
        if (i == 13) return ETH[7:0];
        return 8'(i);
    endfunction

    task automatic send_frame(input int len, input int bad_idx, input logic [7:0] bad_val,
                              input logic user, input int gap, input logic clr_last);
        for (int i = 0; i < len; i++) begin
            logic [7:0] b;
            b = (i == bad_idx) ? bad_val : pat(i);
            if (gap > 0) repeat ($urandom_range(0, gap)) drive(1'b0, 8'($urandom), 1'b0, 1'b0, 1'b0);
            drive(1'b1, b, i == len - 1, i == len - 1 ? user : 1'($urandom), i == len - 1 && clr_last);
        end
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
    endtask

    initial begin
        repeat (3) @(posedge clk_mac);
        #1 rst = 1'b0;
        started = 1;
        @(negedge clk_mac);
        chk("reset good_cnt", good_cnt, 0);
        chk("reset frame_done", frame_done, 0);
        chk("reset last_len", last_len, 0);
        chk("reset rd_data", rd_data, 0);

        send_frame(64, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("t1 frame_done", frame_done, 1);
        chk("t1 frame_ok", frame_ok, 1);
        chk("t1 last_len", last_len, 64);
        chk("t1 good", good_cnt, 1);
        chk("t1 bad+err", bad_cnt + err_cnt, 0);

        send_frame(64, 20, 8'h00, 1'b0, 0, 1'b0);
        chk("t2 bad", bad_cnt, 1);
        chk("t2 frame_ok", frame_ok, 0);
        rand_rd = 0;
        rd_addr = 6'd20;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2 rd 20", rd_data, 8'h00);
        rd_addr = 6'd14;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t2 rd 14", rd_data, 8'h0E);
        rand_rd = 1;

        send_frame(64, -1, 8'h00, 1'b1, 0, 1'b0);
        chk("t3 err", err_cnt, 1);
        chk("t3 good", good_cnt, 1);
        send_frame(63, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("t3 len63", last_len, 63);
        send_frame(65, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("t3 len65", last_len, 65);
        chk("t3 bad", bad_cnt, 3);

        send_frame(64, -1, 8'h00, 1'b0, 5, 1'b0);
        chk("t4 good gaps", good_cnt, 2);
        send_frame(1, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("t4 single bad", bad_cnt, 4);
        chk("t4 single len", last_len, 1);

        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        repeat (17) send_frame(64, -1, 8'h00, 1'b0, 1, 1'b0);
        chk("t5 good4 sat", good4, 15);
        chk("t5 good16", good_cnt, 17);
        send_frame(64, -1, 8'h00, 1'b0, 0, 1'b1);
        chk("t5 clr good4", good4, 0);
        chk("t5 clr good", good_cnt, 0);
        chk("t5 clr ok", frame_ok, 1);

        for (int i = 0; i <= 30; i++) drive(1'b1, pat(i), 1'b0, 1'b0, 1'b0);
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b1;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        rst = 1'b0;
        drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);
        chk("t6 no done", frame_done, 0);
        send_frame(64, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("t6 good", good_cnt, 1);

        send_frame(2100, -1, 8'h00, 1'b0, 0, 1'b0);
        chk("oversize len sat", last_len, 2047);

        for (int f = 0; f < 60; f++) begin
            int len, bi;
            len = ($urandom_range(0, 2) == 0) ? $urandom_range(1, 100) : $urandom_range(FLEN - 2, FLEN + 2);
            bi  = ($urandom_range(0, 3) == 0) ? $urandom_range(0, FLEN - 1) : -1;
            send_frame(len, bi, 8'($urandom), $urandom_range(0, 5) == 0, $urandom_range(0, 2),
                       $urandom_range(0, 9) == 0);
            if ($urandom_range(0, 7) == 0) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b1);
        end
        repeat (3) drive(1'b0, 8'h00, 1'b0, 1'b0, 1'b0);

        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

    initial begin
        #2000000;
        $display("FAIL timeout: bench did not finish");
        $fatal(1);
    end
endmodule
